// File: rtl/gate_test_pkg.sv
// Shared types and constants for the basic-gate test sequencer.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Settle counter width; covers SETTLE_CYCLES up to 255.
  localparam int unsigned CNT_W = 8;

  // Truth tables for common 2-input gates (bit i = output for vector i).
  localparam logic [3:0] NOR2_TT  = 4'b0001;
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] XOR2_TT  = 4'b0110;

  // Number of input vectors for an n-input gate.
  function automatic int unsigned num_vectors(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts settle cycles for the current vector; expire_c flags the last one.
module settle_timer
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt;

  // Settle counter: load restarts at zero, enable advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_test_sequencer.sv
// Sweeps every input vector onto a combinational gate and checks its output
// against a truth table, reporting error count and first failing vector.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [(1 << N_INPUTS)-1:0] TRUTH_TABLE = NOR2_TT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [N_INPUTS-1:0] gate_in,
  input  logic                gate_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_vec
);

  localparam int unsigned NUM_VEC = num_vectors(N_INPUTS);
  localparam int unsigned ERR_W   = N_INPUTS + 1;

  state_t              state, state_nxt;
  logic [N_INPUTS-1:0] vec, vec_nxt;
  logic [N_INPUTS-1:0] gate_in_nxt;
  logic                busy_nxt, done_nxt, pass_nxt;
  logic [N_INPUTS:0]   err_nxt;
  logic                fail_valid_nxt;
  logic [N_INPUTS-1:0] fail_vec_nxt;
  logic                timer_load_c, timer_en_c, expire_c, mismatch_c;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_c),
    .enable   (timer_en_c),
    .expire_c (expire_c)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      gate_in    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      gate_in    <= gate_in_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_valid <= fail_valid_nxt;
      fail_vec   <= fail_vec_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides everything but reset.
  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    gate_in_nxt    = gate_in;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_nxt        = err_count;
    fail_valid_nxt = fail_valid;
    fail_vec_nxt   = fail_vec;
    timer_load_c   = 1'b0;
    timer_en_c     = 1'b0;
    mismatch_c     = (gate_out != TRUTH_TABLE[vec]);

    if (abort) begin
      state_nxt   = IDLE;
      gate_in_nxt = '0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
      pass_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt      = SETTLE;
            vec_nxt        = '0;
            gate_in_nxt    = '0;
            err_nxt        = '0;
            fail_valid_nxt = 1'b0;
            fail_vec_nxt   = '0;
            busy_nxt       = 1'b1;
            done_nxt       = 1'b0;
            pass_nxt       = 1'b0;
            timer_load_c   = 1'b1;
          end
        end
        SETTLE: begin
          if (expire_c) begin
            state_nxt = CHECK;
          end else begin
            timer_en_c = 1'b1;
          end
        end
        CHECK: begin
          if (mismatch_c) begin
            err_nxt = err_count + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid_nxt = 1'b1;
              fail_vec_nxt   = vec;
            end
          end
          if (vec == N_INPUTS'(NUM_VEC - 1)) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end else begin
            state_nxt    = SETTLE;
            vec_nxt      = vec + N_INPUTS'(1);
            gate_in_nxt  = vec + N_INPUTS'(1);
            timer_load_c = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
